dac8564_rx: RTL and testbench



---
 rtl/dac8564_pkg.sv | 54 +++++
 rtl/dac8564_if.sv | 15 +
 rtl/dac8564_sync.sv | 35 +++
 rtl/dac8564_rx.sv | 150 +++++++++++++++
 tb/tb_dac8564_rx.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dac8564_pkg.sv
// Shared types and constants for the DAC8564 serial receiver.
package dac8564_pkg;

  localparam int FRAME_BITS = 24;
  localparam int CNT_W      = 5;
  localparam logic [CNT_W-1:0] LAST_BIT = 5'd23;

  // Device address this receiver answers to
  localparam logic [1:0] DEV_ADDR = 2'b00;

  // LD1:LD0 load codes
  localparam logic [1:0] LD_BUF     = 2'b00;
  localparam logic [1:0] LD_ONE     = 2'b01;
  localparam logic [1:0] LD_ALL     = 2'b10;
  localparam logic [1:0] LD_ALL_ALT = 2'b11;

  // Frame bit-field positions
  localparam int A_HI    = 23;
  localparam int A_LO    = 22;
  localparam int LD_HI   = 21;
  localparam int LD_LO   = 20;
  localparam int SEL_HI  = 18;
  localparam int SEL_LO  = 17;
  localparam int PD0_BIT = 16;
  localparam int DATA_HI = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    WAIT   = 2'd3
  } rx_state_e;

  // Offset binary on the wire -> two's complement (flip the MSB)
  function automatic logic [15:0] offset_to_twos(input logic [15:0] v);
    return {~v[15], v[14:0]};
  endfunction

  // Replace one 16-bit channel in the packed output word; channel 0 is the top slice
  function automatic logic [63:0] set_channel(input logic [63:0] cur,
                                              input logic [1:0]  sel,
                                              input logic [15:0] val);
    logic [63:0] res;
    res = cur;
    case (sel)
      2'd0:    res[63:48] = val;
      2'd1:    res[47:32] = val;
      2'd2:    res[31:16] = val;
      default: res[15:0]  = val;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dac8564_if.sv
// DAC8564 3-wire serial bus plus the decoded receiver outputs.
interface dac8564_if;
  logic        nSync;
  logic        SClk;
  logic        Data;
  logic [63:0] Current;
  logic        Update;
  logic [3:0]  PowerDown;
  logic        FrameError;

  modport master (output nSync, SClk, Data,
                  input  Current, Update, PowerDown, FrameError);
  modport slave  (input  nSync, SClk, Data,
                  output Current, Update, PowerDown, FrameError);
endinterface

// File: rtl/dac8564_sync.sv
// Two-flop synchroniser for one asynchronous pin plus registered edge detector.
// level is delayed one extra stage so it lines up with the rise/fall strobes.
module dac8564_sync (
  input  logic Clk,
  input  logic Reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta_r, sync_r, last_r, rise_r, fall_r;

  // Synchronise the pin and register its edges; everything resets low
  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
      last_r <= 1'b0;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      last_r <= sync_r;
      rise_r <= sync_r & ~last_r;
      fall_r <= last_r & ~sync_r;
    end
  end

  assign level = last_r;
  assign rise  = rise_r;
  assign fall  = fall_r;

endmodule

// File: rtl/dac8564_rx.sv
// DAC8564 serial receiver: oversamples the 3-wire bus, decodes 24-bit frames
// and models the DAC input buffers, output registers and power-down flags.
module dac8564_rx
  import dac8564_pkg::*;
(
  input logic      Clk,
  input logic      Reset,
  dac8564_if.slave bus
);

  logic nsync_level_s, nsync_rise_s, nsync_fall_s;
  logic sclk_level_s, sclk_rise_s, sclk_fall_s;
  logic data_level_s, data_rise_s, data_fall_s;
  logic unused_s;

  dac8564_sync u_sync_nsync (.Clk(Clk), .Reset(Reset), .din(bus.nSync),
                             .level(nsync_level_s), .rise(nsync_rise_s), .fall(nsync_fall_s));
  dac8564_sync u_sync_sclk  (.Clk(Clk), .Reset(Reset), .din(bus.SClk),
                             .level(sclk_level_s), .rise(sclk_rise_s), .fall(sclk_fall_s));
  dac8564_sync u_sync_data  (.Clk(Clk), .Reset(Reset), .din(bus.Data),
                             .level(data_level_s), .rise(data_rise_s), .fall(data_fall_s));

  assign unused_s = &{1'b0, nsync_level_s, sclk_level_s, sclk_rise_s, data_rise_s, data_fall_s};

  rx_state_e             state_r, state_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [FRAME_BITS-1:0] shift_r;
  logic                  early_rise_r;
  logic [3:0][15:0]      buf_r;
  logic [63:0]           current_r;
  logic                  update_r;
  logic [3:0]            pd_r;
  logic                  ferr_r;

  logic             shift_en_s, last_bit_s, abort_s;
  logic [1:0]       addr_s, ld_s, sel_s;
  logic             pd0_s;
  logic [15:0]      value_s;
  logic [3:0][15:0] next_buf_s;

  // Per-cycle strobes: bit capture, final bit, and frame abort (final bit wins a tie)
  always_comb begin
    shift_en_s = (state_r == SHIFT) && sclk_fall_s;
    last_bit_s = shift_en_s && (cnt_r == LAST_BIT);
    abort_s    = (state_r == SHIFT) && nsync_rise_s && !last_bit_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (nsync_fall_s) state_s = SHIFT;
        else              state_s = IDLE;
      end
      SHIFT: begin
        if (last_bit_s)        state_s = COMMIT;
        else if (nsync_rise_s) state_s = IDLE;
        else                   state_s = SHIFT;
      end
      COMMIT: begin
        // nSync may already have risen while the last bit was captured
        if (early_rise_r || nsync_rise_s) state_s = IDLE;
        else                              state_s = WAIT;
      end
      WAIT: begin
        if (nsync_rise_s) state_s = IDLE;
        else              state_s = WAIT;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // Bit counter, shift register and frame-abort pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r        <= 5'd0;
      shift_r      <= 24'd0;
      early_rise_r <= 1'b0;
      ferr_r       <= 1'b0;
    end else begin
      ferr_r       <= abort_s;
      early_rise_r <= last_bit_s && nsync_rise_s;
      if ((state_r == IDLE) && nsync_fall_s) begin
        cnt_r <= 5'd0;
      end else if (shift_en_s) begin
        cnt_r   <= cnt_r + 5'd1;
        shift_r <= {shift_r[FRAME_BITS-2:0], data_level_s};
      end
    end
  end

  // Field decode of the captured frame and the buffer set after a write
  always_comb begin
    addr_s             = shift_r[A_HI:A_LO];
    ld_s               = shift_r[LD_HI:LD_LO];
    sel_s              = shift_r[SEL_HI:SEL_LO];
    pd0_s              = shift_r[PD0_BIT];
    value_s            = offset_to_twos(shift_r[DATA_HI:0]);
    next_buf_s         = buf_r;
    next_buf_s[sel_s]  = value_s;
  end

  // Commit a decoded frame into buffers, output registers and power-down flags
  always_ff @(posedge Clk) begin
    if (Reset) begin
      buf_r     <= 64'd0;
      current_r <= 64'd0;
      pd_r      <= 4'd0;
      update_r  <= 1'b0;
    end else begin
      update_r <= 1'b0;
      if ((state_r == COMMIT) && (addr_s == DEV_ADDR)) begin
        if (pd0_s) begin
          pd_r[sel_s] <= 1'b1;
        end else begin
          buf_r <= next_buf_s;
          case (ld_s)
            LD_BUF: begin
            end
            LD_ONE: begin
              current_r   <= set_channel(current_r, sel_s, value_s);
              pd_r[sel_s] <= 1'b0;
              update_r    <= 1'b1;
            end
            LD_ALL, LD_ALL_ALT: begin
              current_r <= {next_buf_s[0], next_buf_s[1], next_buf_s[2], next_buf_s[3]};
              pd_r      <= 4'd0;
              update_r  <= 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
    end
  end

  assign bus.Current    = current_r;
  assign bus.Update     = update_r;
  assign bus.PowerDown  = pd_r;
  assign bus.FrameError = ferr_r;

endmodule

// File: tb/tb_dac8564_rx.sv
// Scoreboard bench for dac8564_rx: frames are bit-banged onto the bus, a
// reference model pushes expected output words on every loading frame, and a
// monitor pops them when Update pulses.
module tb_dac8564_rx;

  logic Clk;
  logic Reset;

  dac8564_if bus_if ();

  dac8564_rx dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [63:0] cur;
    logic [3:0]  pd;
  } exp_t;

  exp_t        exp_q[$];
  int          check_cnt = 0;
  int          err_cnt   = 0;
  int          upd_cnt   = 0;
  int          ferr_cnt  = 0;
  logic [15:0] m_buf[4];
  logic [15:0] m_cur[4];
  logic [3:0]  m_pd;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] m_pack();
    return {m_cur[0], m_cur[1], m_cur[2], m_cur[3]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_buf[i] = 16'd0;
      m_cur[i] = 16'd0;
    end
    m_pd = 4'd0;
  endtask

  // Reference behaviour of one complete frame; queues the expected word if it loads
  task automatic model_frame(input logic [23:0] f);
    logic [15:0] d;
    logic [1:0]  sel, ld;
    bit          upd;
    exp_t        e;
    upd = 1'b0;
    d   = {~f[15], f[14:0]};
    sel = f[18:17];
    ld  = f[21:20];
    if (f[23:22] == 2'b00) begin
      if (f[16]) begin
        m_pd[sel] = 1'b1;
      end else begin
        m_buf[sel] = d;
        if (ld == 2'b01) begin
          m_cur[sel] = d;
          m_pd[sel]  = 1'b0;
          upd        = 1'b1;
        end else if (ld[1]) begin
          for (int i = 0; i < 4; i++) m_cur[i] = m_buf[i];
          m_pd = 4'd0;
          upd  = 1'b1;
        end
      end
    end
    if (upd) begin
      e.cur = m_pack();
      e.pd  = m_pd;
      exp_q.push_back(e);
    end
  endtask

  // Output monitor: pop expectations on Update, count pulses, check exclusivity
  always @(negedge Clk) begin : monitor
    exp_t e;
    if (bus_if.Update) begin
      upd_cnt++;
      check_value("exp_queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_value("cur_at_update", bus_if.Current, e.cur);
        check_value("pd_at_update", {60'd0, bus_if.PowerDown}, {60'd0, e.pd});
      end
    end
    if (bus_if.FrameError) ferr_cnt++;
    if (bus_if.Update || bus_if.FrameError)
      check_value("upd_ferr_exclusive", 64'(bus_if.Update & bus_if.FrameError), 64'd0);
  end

  // One serial bit: data set while SClk high, sampled on the falling edge
  task automatic clock_bit(input logic b, input int phase);
    bus_if.Data = b;
    repeat (phase) @(posedge Clk);
    #1 bus_if.SClk = 1'b0;
    repeat (phase) @(posedge Clk);
    #1 bus_if.SClk = 1'b1;
  endtask

  task automatic send_frame(input logic [23:0] f, input int nedges, input int phase, input int gap);
    if (nedges >= 24) model_frame(f);
    @(posedge Clk);
    #1 bus_if.nSync = 1'b0;
    repeat (phase) @(posedge Clk);
    #1;
    for (int i = 0; i < nedges; i++)
      clock_bit((i < 24) ? f[23 - i] : 1'($urandom_range(0, 1)), phase);
    bus_if.nSync = 1'b1;
    repeat (gap) @(posedge Clk);
  endtask

  task automatic run_frame(input string tag, input logic [23:0] f, input int nedges,
                           input int exp_upd, input int exp_ferr);
    int u0, e0;
    u0 = upd_cnt;
    e0 = ferr_cnt;
    send_frame(f, nedges, 3, 4);
    repeat (12) @(posedge Clk);
    @(negedge Clk);
    check_value({tag, "_updates"}, 64'(upd_cnt - u0), 64'(exp_upd));
    check_value({tag, "_ferrs"}, 64'(ferr_cnt - e0), 64'(exp_ferr));
    check_value({tag, "_current"}, bus_if.Current, m_pack());
    check_value({tag, "_pd"}, {60'd0, bus_if.PowerDown}, {60'd0, m_pd});
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int          u0, e0;
    logic [15:0] v[4];
    logic [23:0] f;
    model_reset();
    Reset        = 1'b1;
    bus_if.nSync = 1'b0;
    bus_if.SClk  = 1'b1;
    bus_if.Data  = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    check_value("rst_current", bus_if.Current, 64'd0);
    check_value("rst_pd", {60'd0, bus_if.PowerDown}, 64'd0);
    check_value("rst_update", 64'(bus_if.Update), 64'd0);
    check_value("rst_ferr", 64'(bus_if.FrameError), 64'd0);

    // nSync held low through reset must not open a frame
    repeat (6) @(posedge Clk);
    #1 bus_if.nSync = 1'b1;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    check_value("nsync_low_reset_ferrs", 64'(ferr_cnt), 64'd0);

    run_frame("f128000", 24'h12_8000, 24, 1, 0);
    run_frame("f04ffff", 24'h04_FFFF, 24, 0, 0);
    run_frame("f200001", 24'h20_0001, 24, 1, 0);
    check_value("f200001_ch0", 64'(bus_if.Current[63:48]), 64'h8001);
    check_value("f200001_ch2", 64'(bus_if.Current[31:16]), 64'h7FFF);
    run_frame("short12", 24'h12_3456, 12, 0, 1);
    run_frame("f121234", 24'h12_1234, 24, 1, 0);
    check_value("f121234_ch1", 64'(bus_if.Current[47:32]), 64'h9234);
    run_frame("badaddr", 24'hC2_1234, 24, 0, 0);
    run_frame("f110000", 24'h11_0000, 24, 0, 0);
    check_value("f110000_pd", {60'd0, bus_if.PowerDown}, 64'd1);
    run_frame("overrun30", 24'h12_8001, 30, 1, 0);
    check_value("overrun30_ch1", 64'(bus_if.Current[47:32]), 64'h0001);

    // Reset in the middle of a frame
    u0 = upd_cnt;
    e0 = ferr_cnt;
    @(posedge Clk);
    #1 bus_if.nSync = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    for (int i = 0; i < 8; i++) clock_bit(1'b1, 3);
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    model_reset();
    @(negedge Clk);
    check_value("midrst_current", bus_if.Current, 64'd0);
    check_value("midrst_pd", {60'd0, bus_if.PowerDown}, 64'd0);
    @(posedge Clk);
    #1;
    for (int i = 0; i < 4; i++) clock_bit(1'b0, 3);
    bus_if.nSync = 1'b1;
    repeat (12) @(posedge Clk);
    @(negedge Clk);
    check_value("midrst_ferrs", 64'(ferr_cnt - e0), 64'd0);
    check_value("midrst_updates", 64'(upd_cnt - u0), 64'd0);
    run_frame("post_rst", 24'h12_1234, 24, 1, 0);
    check_value("post_rst_word", bus_if.Current, {16'h0000, 16'h9234, 32'h0000_0000});

    // Back-to-back 4-frame bursts at minimum SClk phase and nSync gap
    for (int b = 0; b < 3; b++) begin
      u0 = upd_cnt;
      for (int ch = 0; ch < 4; ch++) v[ch] = 16'($urandom);
      for (int ch = 0; ch < 4; ch++) begin
        f = {2'b00, (ch == 3) ? 2'b10 : 2'b00, 1'b0, 2'(ch), 1'b0, ~v[ch][15], v[ch][14:0]};
        send_frame(f, 24, 2, 1);
      end
      repeat (12) @(posedge Clk);
      @(negedge Clk);
      check_value("burst_updates", 64'(upd_cnt - u0), 64'd1);
      check_value("burst_current", bus_if.Current, {v[0], v[1], v[2], v[3]});
      check_value("burst_pd", {60'd0, bus_if.PowerDown}, 64'd0);
    end

    check_value("exp_queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
